// File: rtl/sar_search_ctrl_pkg.sv
// Purpose: shared state encoding, probe-step codes and flag check for the SAR search controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sar_search_ctrl_pkg;

    // Controller states. Plain constants keep the encoding stable across tools.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Outcome of one probe, computed from the comparator flags.
    localparam logic [1:0] STEP_GO   = 2'd0;  // narrow the bounds and probe again
    localparam logic [1:0] STEP_HIT  = 2'd1;  // guess equals target
    localparam logic [1:0] STEP_MISS = 2'd2;  // target lies outside the range
    localparam logic [1:0] STEP_ERR  = 2'd3;  // comparator flags were not one-hot

    // True when exactly one of the three comparator flags is set.
    function automatic logic flags_onehot(input logic eq, input logic lt, input logic gt);
        return ( eq & ~lt & ~gt) |
               (~eq &  lt & ~gt) |
               (~eq & ~lt &  gt);
    endfunction

endpackage

// File: rtl/sar_search_ctrl_step.sv
// Purpose: combinational probe evaluation: classifies the flags and computes the next bounds and next mid.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent decides when the result is used.
module sar_search_ctrl_step
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   lo,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] guess,
    input  logic             cmp_equal,
    input  logic             cmp_lower,
    input  logic             cmp_greater,
    output logic [1:0]       step,
    output logic [WIDTH:0]   nxt_lo,
    output logic [WIDTH:0]   nxt_hi,
    output logic [WIDTH-1:0] nxt_guess
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    // Bounds are one bit wider than the operand, so guess+1 and guess-1 never wrap.
    logic [WIDTH:0] guess_w;
    logic           flags_ok;

    assign guess_w  = {1'b0, guess};
    assign flags_ok = flags_onehot(cmp_equal, cmp_lower, cmp_greater);

    // Classify the probe and shrink the interval on the side the target cannot be.
    always_comb begin
        step   = STEP_GO;
        nxt_lo = lo;
        nxt_hi = hi;
        if (!flags_ok) begin
            step = STEP_ERR;
        end else if (cmp_equal) begin
            step = STEP_HIT;
        end else if (cmp_lower) begin
            if (guess_w == hi) begin
                step = STEP_MISS;
            end else begin
                nxt_lo = guess_w + ONE;
            end
        end else begin
            if (guess_w == lo) begin
                step = STEP_MISS;
            end else begin
                nxt_hi = guess_w - ONE;
            end
        end
    end

    // Midpoint written as lo + half-span so it never overflows; it is always <= hi,
    // so the top bit of the wide sum is always zero and can be dropped.
    assign nxt_guess = WIDTH'(nxt_lo + ((nxt_hi - nxt_lo) >> 1));

endmodule

// File: rtl/sar_search_ctrl.sv
// Purpose: binary-search initiator driving comparator operand "a" to locate the hidden target in [search_lo, search_hi].
// Latency: start accepted at T, one probe per cycle from T+1, done pulse at T+1+N (N <= WIDTH+1).
// Backpressure: start is honoured only in IDLE; starts while busy or in DONE are dropped, not queued.
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] search_lo,
    input  logic [WIDTH-1:0] search_hi,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_equal,
    input  logic             cmp_lower,
    input  logic             cmp_greater,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] probes
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [WIDTH:0]   lo;
    logic [WIDTH:0]   hi;

    logic [1:0]       step;
    logic [WIDTH:0]   nxt_lo;
    logic [WIDTH:0]   nxt_hi;
    logic [WIDTH-1:0] nxt_guess;
    logic [WIDTH-1:0] first_guess;
    logic             range_ok;

    // Next-probe evaluation against the guess currently presented to the comparator.
    sar_search_ctrl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .lo          (lo),
        .hi          (hi),
        .guess       (guess),
        .cmp_equal   (cmp_equal),
        .cmp_lower   (cmp_lower),
        .cmp_greater (cmp_greater),
        .step        (step),
        .nxt_lo      (nxt_lo),
        .nxt_hi      (nxt_hi),
        .nxt_guess   (nxt_guess)
    );

    // First probe straight from the requested bounds; lo + half-span stays within WIDTH bits when lo <= hi.
    assign range_ok    = (search_lo <= search_hi);
    assign first_guess = search_lo + ((search_hi - search_lo) >> 1);

    // Status strobes decode directly from the state register.
    assign busy = (state == ST_PROBE);
    assign done = (state == ST_DONE);

    // State machine plus all data registers; reset aborts any search without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            lo     <= '0;
            hi     <= '0;
            guess  <= '0;
            result <= '0;
            probes <= '0;
            found  <= 1'b0;
            error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        result <= '0;
                        probes <= '0;
                        found  <= 1'b0;
                        error  <= 1'b0;
                        if (range_ok) begin
                            lo    <= {1'b0, search_lo};
                            hi    <= {1'b0, search_hi};
                            guess <= first_guess;
                            state <= ST_PROBE;
                        end else begin
                            // Empty range: report not-found without probing.
                            state <= ST_DONE;
                        end
                    end
                end
                ST_PROBE: begin
                    probes <= probes + CNT_ONE;
                    case (step)
                        STEP_ERR: begin
                            error <= 1'b1;
                            found <= 1'b0;
                            state <= ST_DONE;
                        end
                        STEP_HIT: begin
                            result <= guess;
                            found  <= 1'b1;
                            state  <= ST_DONE;
                        end
                        STEP_MISS: begin
                            found <= 1'b0;
                            state <= ST_DONE;
                        end
                        default: begin
                            lo    <= nxt_lo;
                            hi    <= nxt_hi;
                            guess <= nxt_guess;
                        end
                    endcase
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
module tb_sar_search_ctrl;

    localparam int W = 8;
    localparam int MAXCYC = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] search_lo;
    logic [W-1:0] search_hi;
    logic [W-1:0] guess;
    logic         cmp_equal;
    logic         cmp_lower;
    logic         cmp_greater;
    logic         busy;
    logic         done;
    logic         found;
    logic         error;
    logic [W-1:0] result;
    logic [3:0]   probes;

    // Comparator stand-in, with an override for illegal flag patterns.
    logic [W-1:0] target;
    logic         force_en;
    logic [2:0]   force_flags;

    int n_cmp;
    int n_bad;

    // Reference expectations.
    int exp_seq[$];
    bit exp_found;
    int exp_result;

    assign cmp_equal   = force_en ? force_flags[2] : (guess == target);
    assign cmp_lower   = force_en ? force_flags[1] : (guess <  target);
    assign cmp_greater = force_en ? force_flags[0] : (guess >  target);

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .search_lo   (search_lo),
        .search_hi   (search_hi),
        .guess       (guess),
        .cmp_equal   (cmp_equal),
        .cmp_lower   (cmp_lower),
        .cmp_greater (cmp_greater),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .error       (error),
        .result      (result),
        .probes      (probes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Binary search over integers: the probe list, hit flag and result.
    task automatic model(input int lo, input int hi, input int tgt);
        int l;
        int h;
        int m;
        l = lo;
        h = hi;
        exp_seq.delete();
        exp_found  = 1'b0;
        exp_result = 0;
        if (lo > hi) return;
        for (int k = 0; k < 64; k++) begin
            m = l + (h - l) / 2;
            exp_seq.push_back(m);
            if (m == tgt) begin
                exp_found  = 1'b1;
                exp_result = m;
                return;
            end else if (m < tgt) begin
                if (m == h) return;
                l = m + 1;
            end else begin
                if (m == l) return;
                h = m - 1;
            end
        end
    endtask

    // One full search; optionally hammers start while busy/done to prove it is dropped.
    task automatic run_search(input int lo, input int hi, input int tgt, input bit poke, input string nm);
        int got[$];
        int cyc;
        int n;
        model(lo, hi, tgt);
        n = exp_seq.size();
        target = W'(tgt);
        @(negedge clk);
        search_lo = W'(lo);
        search_hi = W'(hi);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < MAXCYC) begin
            if (busy) got.push_back(int'(guess));
            start = poke ? (busy | done) : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = poke ? 1'b1 : 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s timeout: done not seen after %0d cycles, required at %0d", nm, cyc, 1 + n);
        end else begin
            n_cmp++;
            if (cyc != 1 + n) begin
                n_bad++;
                $display("FAIL %s latency: done at T+%0d, required T+%0d", nm, cyc, 1 + n);
            end
            n_cmp++;
            if (got.size() != n) begin
                n_bad++;
                $display("FAIL %s probe count seen: %0d, required %0d", nm, got.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_cmp++;
                    if (got[i] != exp_seq[i]) begin
                        n_bad++;
                        $display("FAIL %s probe[%0d]: got %0d, required %0d", nm, i, got[i], exp_seq[i]);
                    end
                end
            end
            n_cmp++;
            if (found !== exp_found) begin
                n_bad++;
                $display("FAIL %s found: got %b, required %b", nm, found, exp_found);
            end
            n_cmp++;
            if (result !== W'(exp_result)) begin
                n_bad++;
                $display("FAIL %s result: got %0d, required %0d", nm, result, exp_result);
            end
            n_cmp++;
            if (probes !== 4'(n)) begin
                n_bad++;
                $display("FAIL %s probes: got %0d, required %0d", nm, probes, n);
            end
            n_cmp++;
            if (error !== 1'b0) begin
                n_bad++;
                $display("FAIL %s error: got %b, required 0", nm, error);
            end
        end
        // DONE lasts one cycle, and a start poked during DONE must not relaunch.
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s post-done: done=%b busy=%b, required 0/0", nm, done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || found !== exp_found) begin
            n_bad++;
            $display("FAIL %s hold: busy=%b found=%b, required 0/%b", nm, busy, found, exp_found);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        search_lo = 8'd0;
        search_hi = 8'd255;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({guess, result, probes, busy, done, found, error} !== '0) begin
            n_bad++;
            $display("FAIL reset state: guess=%0d result=%0d probes=%0d busy=%b done=%b found=%b error=%b, required all 0",
                     guess, result, probes, busy, done, found, error);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset start-with-rst: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_directed();
        run_search(0, 255, 127, 1'b0, "mid_hit");
        n_cmp++;
        if (probes !== 4'd1 || result !== 8'd127) begin
            n_bad++;
            $display("FAIL mid_hit literal: probes=%0d result=%0d, required 1/127", probes, result);
        end
        run_search(0, 255, 255, 1'b0, "top_hit");
        n_cmp++;
        if (probes !== 4'd9 || result !== 8'd255 || guess !== 8'd255) begin
            n_bad++;
            $display("FAIL top_hit literal: probes=%0d result=%0d guess=%0d, required 9/255/255", probes, result, guess);
        end
        run_search(0, 255, 0, 1'b0, "bottom_hit");
        n_cmp++;
        if (probes !== 4'd8 || found !== 1'b1 || result !== 8'd0) begin
            n_bad++;
            $display("FAIL bottom_hit literal: probes=%0d found=%b result=%0d, required 8/1/0", probes, found, result);
        end
        run_search(10, 20, 50, 1'b0, "above_range");
        n_cmp++;
        if (probes !== 4'd4 || found !== 1'b0 || guess !== 8'd20) begin
            n_bad++;
            $display("FAIL above_range literal: probes=%0d found=%b guess=%0d, required 4/0/20", probes, found, guess);
        end
        run_search(100, 200, 5, 1'b0, "below_range");
        run_search(20, 10, 15, 1'b0, "empty_range");
        run_search(77, 77, 77, 1'b0, "single_point");
    endtask

    task automatic test_error();
        int cyc;
        force_en = 1'b1;
        force_flags = 3'b000;
        @(negedge clk);
        search_lo = 8'd0;
        search_hi = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < MAXCYC) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!done || cyc != 2) begin
            n_bad++;
            $display("FAIL error_flags latency: done=%b at T+%0d, required done at T+2", done, cyc);
        end
        n_cmp++;
        if (error !== 1'b1 || found !== 1'b0 || probes !== 4'd1) begin
            n_bad++;
            $display("FAIL error_flags status: error=%b found=%b probes=%0d, required 1/0/1", error, found, probes);
        end
        force_flags = 3'b110;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL error_hold: error=%b, required 1", error);
        end
        force_en = 1'b0;
        // A fresh search clears the sticky error (run_search checks error==0).
        run_search(0, 255, 200, 1'b0, "after_error");
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit saw_done;
        target = 8'd0;
        @(negedge clk);
        search_lo = 8'd0;
        search_hi = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 3) begin
            start = 1'b1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || guess !== 8'd31) begin
            n_bad++;
            $display("FAIL busy_start_ignored: busy=%b guess=%0d at third probe, required 1/31", busy, guess);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({guess, result, probes, busy, done, found, error} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: guess=%0d result=%0d probes=%0d busy=%b done=%b found=%b error=%b, required all 0",
                     guess, result, probes, busy, done, found, error);
        end
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: done/busy seen after abort, required none");
        end
    endtask

    task automatic test_back_to_back();
        run_search(0, 255, 129, 1'b1, "poke_a");
        run_search(3, 250, 250, 1'b1, "poke_b");
        run_search(0, 255, 64, 1'b0, "b2b_a");
        run_search(0, 255, 65, 1'b0, "b2b_b");
    endtask

    task automatic test_random();
        int lo;
        int hi;
        int tgt;
        for (int i = 0; i < 30; i++) begin
            lo = $urandom_range(0, 255);
            hi = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0 && lo <= hi)
                tgt = $urandom_range(lo, hi);
            else
                tgt = $urandom_range(0, 255);
            run_search(lo, hi, tgt, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b0;
        search_lo = '0;
        search_hi = '0;
        target = '0;
        force_en = 1'b0;
        force_flags = 3'b000;
        test_reset();
        test_directed();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
